// File: rtl/icache_ctrl_pkg.sv
// Shared line geometry and controller state encoding for the instruction cache
// and the fetch queue that talks to it.
package icache_ctrl_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 4;
  localparam int LINE_BITS      = LINE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-queue request/response signals and the refill read port to instruction memory.
interface icache_ctrl_if;
  import icache_ctrl_pkg::*;

  logic [31:0]          icache_pcin;
  logic                 icache_ren;
  logic                 icache_abort;
  logic                 icache_flush;
  logic [LINE_BITS-1:0] icache_dout;
  logic                 icache_dout_valid;
  logic                 icache_busy;
  logic [31:0]          mem_addr;
  logic                 mem_ren;
  logic [31:0]          mem_rdata;
  logic                 mem_rvalid;

  modport slave (
    input  icache_pcin, icache_ren, icache_abort, icache_flush, mem_rdata, mem_rvalid,
    output icache_dout, icache_dout_valid, icache_busy, mem_addr, mem_ren
  );

  modport master (
    output icache_pcin, icache_ren, icache_abort, icache_flush, mem_rdata, mem_rvalid,
    input  icache_dout, icache_dout_valid, icache_busy, mem_addr, mem_ren
  );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage: combinational lookup, one write port,
// single-cycle invalidate of every line.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - OFFSET_W - IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic [TAG_W-1:0]     rd_tag,
  output logic                 hit,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_data
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] data_d [NUM_LINES];

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  // NOTE: every always_comb output is given its hold value before any branch, so no latch can form.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: tag and data storage is deliberately left unreset; clearing the valid bits makes its content unreachable.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: one-cycle hits, and a
// four-word sequential refill from instruction memory on a miss.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         reset,
  icache_ctrl_if.slave bus
);

  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - OFFSET_W - IDX_W;
  localparam int LADDR_W = 32 - OFFSET_W;

  state_e                       state_q, state_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic                         abort_q, abort_d;
  logic [LADDR_W-1:0]           line_addr_q, line_addr_d;
  logic [WORDS_PER_LINE-2:0][31:0] buf_q, buf_d;
  logic [LINE_BITS-1:0]         dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;

  logic                 arr_hit;
  logic [LINE_BITS-1:0] arr_rd_data;
  logic [LINE_BITS-1:0] fill_line;
  logic                 arr_wr_en;
  logic                 arr_flush;
  logic                 pc_offset_unused;

  assign pc_offset_unused = ^bus.icache_pcin[OFFSET_W-1:0];

  // The last refill word bypasses the buffer so the line installs on the same edge it arrives.
  assign fill_line = {bus.mem_rdata, buf_q[2], buf_q[1], buf_q[0]};

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .flush   (arr_flush),
    .rd_idx  (bus.icache_pcin[OFFSET_W+IDX_W-1:OFFSET_W]),
    .rd_tag  (bus.icache_pcin[31:OFFSET_W+IDX_W]),
    .hit     (arr_hit),
    .rd_data (arr_rd_data),
    .wr_en   (arr_wr_en),
    .wr_idx  (line_addr_q[IDX_W-1:0]),
    .wr_tag  (line_addr_q[LADDR_W-1:IDX_W]),
    .wr_data (fill_line)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    line_addr_d  = line_addr_q;
    buf_d        = buf_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    arr_wr_en    = 1'b0;
    arr_flush    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.icache_flush) begin
          arr_flush = 1'b1;
        end else if (bus.icache_ren) begin
          if (arr_hit) begin
            dout_d       = arr_rd_data;
            dout_valid_d = 1'b1;
          end else begin
            line_addr_d = bus.icache_pcin[31:OFFSET_W];
            cnt_d       = 2'd0;
            abort_d     = 1'b0;
            state_d     = REQ;
          end
        end
      end

      REQ: begin
        abort_d = abort_q | bus.icache_abort;
        state_d = WAIT;
      end

      WAIT: begin
        abort_d = abort_q | bus.icache_abort;
        if (bus.mem_rvalid) begin
          if (cnt_q != 2'd3) begin
            buf_d[cnt_q] = bus.mem_rdata;
            cnt_d        = cnt_q + 2'd1;
            state_d      = REQ;
          end else begin
            // An aborted refill still installs the line; only the response is withheld.
            arr_wr_en    = 1'b1;
            dout_d       = fill_line;
            dout_valid_d = !(abort_q | bus.icache_abort);
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      abort_q      <= 1'b0;
      line_addr_q  <= '0;
      buf_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      line_addr_q  <= line_addr_d;
      buf_q        <= buf_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.icache_dout       = dout_q;
  assign bus.icache_dout_valid = dout_valid_q;
  assign bus.icache_busy       = (state_q != IDLE);
  assign bus.mem_ren           = (state_q == REQ);
  assign bus.mem_addr          = {line_addr_q, cnt_q, 2'b00};

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus randomized
// traffic checked against a line-level cache model and a latency-L memory.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  localparam int NUM_LINES = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  icache_ctrl_if bus();

  icache_ctrl #(.NUM_LINES(NUM_LINES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  logic [31:0] mem_log[$];

  // Reference cache: which line number (pc >> 4) each set currently holds.
  bit          mvalid[NUM_LINES];
  int unsigned mline [NUM_LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h40 && a < 32'h50) return 32'h11 * ((a - 32'h40) / 4 + 1);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] pc);
    logic [31:0] base;
    base = pc & 32'hFFFF_FFF0;
    return {mem_word(base + 12), mem_word(base + 8), mem_word(base + 4), mem_word(base)};
  endfunction

  // Instruction memory: answers each read strobe mem_lat cycles later.
  initial begin
    logic [31:0] a;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ren === 1'b1) begin
        a = bus.mem_addr;
        repeat (mem_lat) @(posedge clk);
        #1 bus.mem_rvalid = 1'b1;
        bus.mem_rdata = mem_word(a);
        @(posedge clk);
        #1 bus.mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_ren === 1'b1) mem_log.push_back(bus.mem_addr);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    for (int i = 0; i < NUM_LINES; i++) mvalid[i] = 1'b0;
  endtask

  // One request at cycle 0, optional abort / busy-time ren / busy-time flush at given cycles.
  task automatic do_req(input logic [31:0] pc, input int abort_at, input int extra_at,
                        input logic [31:0] extra_pc, input int flush_at, input string nm);
    int unsigned lineno;
    int idx, window, exp_lat, first, nvalid, exp_n;
    bit hit, aborted;
    logic [127:0] seen;
    lineno  = pc >> 4;
    idx     = int'(lineno % NUM_LINES);
    hit     = mvalid[idx] && (mline[idx] == lineno);
    window  = hit ? 3 : 4 * (1 + mem_lat) + 3;
    aborted = !hit && abort_at >= 1 && abort_at <= 4 * (1 + mem_lat);
    exp_lat = hit ? 1 : (aborted ? -1 : 4 * (1 + mem_lat) + 1);
    exp_n   = hit ? 0 : 4;
    first   = -1;
    nvalid  = 0;
    seen    = '0;
    mem_log.delete();
    @(posedge clk);
    #1 bus.icache_pcin = pc;
    bus.icache_ren = 1'b1;
    for (int cyc = 1; cyc <= window; cyc++) begin
      @(posedge clk);
      #1 bus.icache_ren = (cyc == extra_at);
      if (cyc == extra_at) bus.icache_pcin = extra_pc;
      bus.icache_abort = (cyc == abort_at);
      bus.icache_flush = (cyc == flush_at);
      @(negedge clk);
      if (bus.icache_dout_valid === 1'b1) begin
        nvalid++;
        if (first < 0) begin
          first = cyc;
          seen  = bus.icache_dout;
        end
      end
    end
    bus.icache_abort = 1'b0;
    bus.icache_flush = 1'b0;
    bus.icache_ren   = 1'b0;

    checks++;
    if (first != exp_lat) begin
      errors++;
      $display("FAIL %s latency pc=%h got=%0d exp=%0d", nm, pc, first, exp_lat);
    end
    checks++;
    if (nvalid != (exp_lat < 0 ? 0 : 1)) begin
      errors++;
      $display("FAIL %s pulse_count pc=%h got=%0d exp=%0d", nm, pc, nvalid, (exp_lat < 0 ? 0 : 1));
    end
    if (exp_lat > 0 && first == exp_lat) begin
      checks++;
      if (seen !== line_of(pc)) begin
        errors++;
        $display("FAIL %s dout pc=%h got=%h exp=%h", nm, pc, seen, line_of(pc));
      end
    end
    checks++;
    if (mem_log.size() != exp_n) begin
      errors++;
      $display("FAIL %s mem_reads pc=%h got=%0d exp=%0d", nm, pc, mem_log.size(), exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        checks++;
        if (mem_log[i] !== (lineno << 4) + 32'(4 * i)) begin
          errors++;
          $display("FAIL %s mem_addr[%0d] got=%h exp=%h", nm, i, mem_log[i], (lineno << 4) + 32'(4 * i));
        end
      end
    end
    checks++;
    if (bus.icache_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after got=%b exp=0", nm, bus.icache_busy);
    end
    if (!hit) begin
      mvalid[idx] = 1'b1;
      mline[idx]  = lineno;
    end
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1 bus.icache_flush = 1'b1;
    bus.icache_ren  = 1'b1;
    bus.icache_pcin = 32'h48;
    @(posedge clk);
    #1 bus.icache_flush = 1'b0;
    bus.icache_ren = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.icache_dout_valid !== 1'b0 || bus.icache_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_drops_ren dv=%b busy=%b exp=0,0", bus.icache_dout_valid, bus.icache_busy);
    end
    model_clear();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.icache_dout !== '0 || bus.icache_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset dout dout=%h dv=%b exp=0,0", bus.icache_dout, bus.icache_dout_valid);
    end
    checks++;
    if (bus.mem_ren !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset mem ren=%b addr=%h exp=0,0", bus.mem_ren, bus.mem_addr);
    end
    checks++;
    if (bus.icache_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset busy got=%b exp=0", bus.icache_busy);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_cold_miss();
    bit exp_mren, exp_busy, exp_dv;
    mem_lat = 1;
    mem_log.delete();
    @(posedge clk);
    #1 bus.icache_pcin = 32'h40;
    bus.icache_ren = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk);
      #1 bus.icache_ren = 1'b0;
      @(negedge clk);
      exp_mren = (cyc == 1 || cyc == 3 || cyc == 5 || cyc == 7);
      exp_busy = (cyc >= 1 && cyc <= 8);
      exp_dv   = (cyc == 9);
      checks++;
      if (bus.mem_ren !== exp_mren) begin
        errors++;
        $display("FAIL cold_miss mem_ren cyc=%0d got=%b exp=%b", cyc, bus.mem_ren, exp_mren);
      end
      if (exp_mren) begin
        checks++;
        if (bus.mem_addr !== 32'h40 + 32'(4 * ((cyc - 1) / 2))) begin
          errors++;
          $display("FAIL cold_miss mem_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, 32'h40 + 32'(4 * ((cyc - 1) / 2)));
        end
      end
      checks++;
      if (bus.icache_busy !== exp_busy) begin
        errors++;
        $display("FAIL cold_miss busy cyc=%0d got=%b exp=%b", cyc, bus.icache_busy, exp_busy);
      end
      checks++;
      if (bus.icache_dout_valid !== exp_dv) begin
        errors++;
        $display("FAIL cold_miss dout_valid cyc=%0d got=%b exp=%b", cyc, bus.icache_dout_valid, exp_dv);
      end
      if (exp_dv) begin
        checks++;
        if (bus.icache_dout !== 128'h00000044_00000033_00000022_00000011) begin
          errors++;
          $display("FAIL cold_miss dout got=%h exp=%h", bus.icache_dout, 128'h00000044_00000033_00000022_00000011);
        end
      end
    end
    mvalid[4] = 1'b1;
    mline[4]  = 32'h4;
  endtask

  task automatic test_hit();
    bit exp_dv;
    mem_log.delete();
    @(posedge clk);
    #1 bus.icache_pcin = 32'h48;
    bus.icache_ren = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk);
      #1 bus.icache_ren = (cyc < 3);
      @(negedge clk);
      exp_dv = (cyc <= 3);
      checks++;
      if (bus.icache_dout_valid !== exp_dv) begin
        errors++;
        $display("FAIL hit dout_valid cyc=%0d got=%b exp=%b", cyc, bus.icache_dout_valid, exp_dv);
      end
      if (exp_dv) begin
        checks++;
        if (bus.icache_dout !== line_of(32'h48)) begin
          errors++;
          $display("FAIL hit dout cyc=%0d got=%h exp=%h", cyc, bus.icache_dout, line_of(32'h48));
        end
      end
    end
    checks++;
    if (mem_log.size() != 0) begin
      errors++;
      $display("FAIL hit mem_reads got=%0d exp=0", mem_log.size());
    end
  endtask

  task automatic test_conflict();
    mem_lat = 1;
    do_req(32'h140, 0, 0, 32'h0, 0, "conflict_140");
    do_req(32'h40,  0, 0, 32'h0, 0, "conflict_40");
  endtask

  task automatic test_abort();
    mem_lat = 1;
    do_req(32'h80, 3, 0, 32'h0, 0, "abort_miss");
    do_req(32'h80, 0, 0, 32'h0, 0, "abort_rehit");
  endtask

  task automatic test_flush_ignored();
    mem_lat = 1;
    do_req(32'hC0, 0, 4, 32'h48, 5, "busy_ren_flush");
    do_req(32'h48, 0, 0, 32'h0, 0, "busy_flush_kept");
    do_flush();
    do_req(32'h40, 0, 0, 32'h0, 0, "after_flush");
  endtask

  task automatic test_reset_wait();
    mem_lat = 1;
    @(posedge clk);
    #1 bus.icache_pcin = 32'h200;
    bus.icache_ren = 1'b1;
    @(posedge clk);
    #1 bus.icache_ren = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.icache_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait busy_before got=%b exp=1", bus.icache_busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_ren !== 1'b0 || bus.icache_dout_valid !== 1'b0 || bus.icache_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait outputs ren=%b dv=%b busy=%b exp=0,0,0",
               bus.mem_ren, bus.icache_dout_valid, bus.icache_busy);
    end
    checks++;
    if (bus.icache_dout !== '0) begin
      errors++;
      $display("FAIL reset_wait dout got=%h exp=0", bus.icache_dout);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    do_req(32'h200, 0, 0, 32'h0, 0, "reset_wait_refetch");
    do_req(32'h48,  0, 0, 32'h0, 0, "reset_wait_old_line");
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int abort_at;
    for (int n = 0; n < 60; n++) begin
      mem_lat  = int'($urandom_range(1, 3));
      pc       = (32'($urandom_range(0, 3)) << (4 + $clog2(NUM_LINES)))
               | (32'($urandom_range(0, NUM_LINES - 1)) << 4)
               | 32'($urandom_range(0, 15));
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0;
      if ($urandom_range(0, 9) == 0) do_flush();
      do_req(pc, abort_at, 0, 32'h0, 0, "random");
    end
  endtask

  initial begin
    bus.icache_pcin  = '0;
    bus.icache_ren   = 1'b0;
    bus.icache_abort = 1'b0;
    bus.icache_flush = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_abort();
    test_flush_ignored();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
